hs_multi_source: RTL and testbench

HS_MULTI_SOURCE -- requirements
Module: hs_multi_source

---
 rtl/hs_multi_source.sv | 175 +++++++++++++++++
 tb/tb_hs_multi_source.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_multi_source.sv
// hs_multi_source
//
// Round-robin arbiter that picks one of NUM_CH valid/ready source channels, captures its
// payload and hands it to a CDC pulse synchroniser as a one-cycle xfer_req. The block then
// waits for the synchronised xfer_ack before it accepts the next channel.
//
// Optional feature (macro HS_MULTI_SOURCE_TIMEOUT_EN):
//   When defined, a wait counter limits the time spent in WAIT_ACK to TIMEOUT_CYCLES. On
//   expiry it pulses timeout_err and returns to IDLE. When undefined, there is no counter,
//   timeout_err is tied low and WAIT_ACK waits indefinitely.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   ch_valid     in   [NUM_CH]            per-channel request
//   ch_data      in   [NUM_CH*DATA_WIDTH] channel i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_ready     out  [NUM_CH]            combinational accept strobe, at most one bit high
//   xfer_req     out                      one-cycle send pulse (SEND state)
//   xfer_data    out  [DATA_WIDTH]        captured payload, changes only on accept
//   xfer_ch      out  [CH_W]              index of the captured channel
//   xfer_ack     in                       ack pulse, already synchronised into clk
//   busy         out                      high whenever the FSM is not IDLE
//   timeout_err  out                      one-cycle pulse on ack timeout
module hs_multi_source #(
   parameter int unsigned DATA_WIDTH     = 4,
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            ch_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
   output logic [NUM_CH-1:0]            ch_ready,
   output logic                         xfer_req,
   output logic [DATA_WIDTH-1:0]        xfer_data,
   output logic [CH_W-1:0]              xfer_ch,
   input  logic                         xfer_ack,
   output logic                         busy,
   output logic                         timeout_err
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StSend    = 2'd1,
      StWaitAck = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [DATA_WIDTH-1:0] xfer_data_q, xfer_data_d;
   logic [CH_W-1:0]       xfer_ch_q, xfer_ch_d;

   // Grant search: first valid channel at or above rr_ptr, wrapping at NUM_CH-1.
   logic                  grant_found;
   logic [CH_W-1:0]       grant_idx;
   logic [CH_W:0]         cand;
   logic                  accept;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         // One spare bit keeps rr_ptr + i from overflowing before the wrap.
         cand = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
         if (cand >= (CH_W+1)'(NUM_CH)) begin
            cand = cand - (CH_W+1)'(NUM_CH);
         end
         if (!grant_found && ch_valid[cand[CH_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[CH_W-1:0];
         end
      end
   end

   // ch_ready is held low during reset so nothing is accepted while rst is asserted.
   always_comb begin
      ch_ready = '0;
      if (state_q == StIdle && grant_found && !rst) begin
         ch_ready[grant_idx] = 1'b1;
      end
   end

   assign accept = |ch_ready;

`ifdef HS_MULTI_SOURCE_TIMEOUT_EN
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        timeout_err_q, timeout_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      xfer_data_d = xfer_data_q;
      xfer_ch_d   = xfer_ch_q;
`ifdef HS_MULTI_SOURCE_TIMEOUT_EN
      wait_cnt_d    = wait_cnt_q;
      timeout_err_d = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               xfer_data_d = ch_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
               xfer_ch_d   = grant_idx;
               rr_ptr_d    = (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
               state_d     = StSend;
            end
         end
         StSend: begin
            // Acks here belong to nothing in flight and are ignored.
            state_d = StWaitAck;
`ifdef HS_MULTI_SOURCE_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
         StWaitAck: begin
            if (xfer_ack) begin
               state_d = StIdle;
            end else begin
`ifdef HS_MULTI_SOURCE_TIMEOUT_EN
               wait_cnt_d = wait_cnt_q + 16'd1;
               // Counter reaches the limit at this edge; an ack in the same cycle wins above.
               if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                  timeout_err_d = 1'b1;
                  state_d       = StIdle;
               end
`endif
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         xfer_data_q <= '0;
         xfer_ch_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         xfer_data_q <= xfer_data_d;
         xfer_ch_q   <= xfer_ch_d;
      end
   end

`ifdef HS_MULTI_SOURCE_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_err        = 1'b0;
`endif

   // Gated by rst so a reset landing on the SEND cycle emits no pulse.
   assign xfer_req  = (state_q == StSend) && !rst;
   assign xfer_data = xfer_data_q;
   assign xfer_ch   = xfer_ch_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_hs_multi_source.sv
module tb_hs_multi_source;

   localparam int unsigned DW = 4;
   localparam int unsigned NC = 4;
   localparam int unsigned TO = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [NC-1:0]   ch_valid;
   logic [NC*DW-1:0] ch_data;
   logic [NC-1:0]   ch_ready;
   logic            xfer_req;
   logic [DW-1:0]   xfer_data;
   logic [1:0]      xfer_ch;
   logic            xfer_ack;
   logic            busy;
   logic            timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   hs_multi_source #(
      .DATA_WIDTH     (DW),
      .NUM_CH         (NC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ch_valid    (ch_valid),
      .ch_data     (ch_data),
      .ch_ready    (ch_ready),
      .xfer_req    (xfer_req),
      .xfer_data   (xfer_data),
      .xfer_ch     (xfer_ch),
      .xfer_ack    (xfer_ack),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      ch_valid = '0;
      ch_data  = '0;
      xfer_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      ch_valid = 4'b1111;
      ch_data  = 16'hFFFF;
      xfer_ack = 1'b0;
      tick();
      tick();
      n_checks++;
      if (ch_ready !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ready: got %b want 0000", ch_ready);
      end
      n_checks++;
      if ({busy, xfer_req, timeout_err} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, xfer_req, timeout_err});
      end
      n_checks++;
      if ({xfer_data, xfer_ch} !== 6'h00) begin
         n_fail++; $display("FAIL reset_xfer: got %h/%0d want 0/0", xfer_data, xfer_ch);
      end
      // First cycle with rst low can already accept (rr_ptr=0, ch1 wins over ch3).
      rst      = 1'b0;
      ch_valid = 4'b1010;
      ch_data  = 16'h0050;
      #1;
      n_checks++;
      if (ch_ready !== 4'b0010) begin
         n_fail++; $display("FAIL first_accept_ready: got %b want 0010", ch_ready);
      end
      tick();
      n_checks++;
      if (xfer_req !== 1'b1 || xfer_ch !== 2'd1 || xfer_data !== 4'h5) begin
         n_fail++; $display("FAIL first_accept_xfer: got req=%b ch=%0d data=%h want 1/1/5",
                            xfer_req, xfer_ch, xfer_data);
      end
      ch_valid = '0;
   endtask

   task automatic test_single();
      do_reset();
      ch_valid = 4'b0100;
      ch_data  = 16'h0A00;
      #1;
      n_checks++;
      if (ch_ready !== 4'b0100) begin
         n_fail++; $display("FAIL single_ready: got %b want 0100", ch_ready);
      end
      tick();  // T+1
      ch_valid = '0;
      ch_data  = 16'h5555;
      #1;
      n_checks++;
      if (xfer_req !== 1'b1 || xfer_data !== 4'hA || xfer_ch !== 2'd2 || busy !== 1'b1) begin
         n_fail++; $display("FAIL single_send: got req=%b data=%h ch=%0d busy=%b want 1/a/2/1",
                            xfer_req, xfer_data, xfer_ch, busy);
      end
      tick();  // T+2
      n_checks++;
      if (xfer_req !== 1'b0 || busy !== 1'b1 || xfer_data !== 4'hA) begin
         n_fail++; $display("FAIL single_wait: got req=%b busy=%b data=%h want 0/1/a",
                            xfer_req, busy, xfer_data);
      end
      tick();  // T+3
      xfer_ack = 1'b1;
      tick();  // T+4
      xfer_ack = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || xfer_data !== 4'hA) begin
         n_fail++; $display("FAIL single_done: got busy=%b data=%h want 0/a", busy, xfer_data);
      end
   endtask

   task automatic test_round_robin();
      int exp_order [5];
      logic [3:0] exp_ready;
      exp_order = '{0, 1, 2, 3, 0};
      do_reset();
      ch_valid = 4'b1111;
      ch_data  = 16'h4321;
      for (int k = 0; k < 5; k++) begin
         #1;
         exp_ready = 4'b0001 << exp_order[k];
         n_checks++;
         if (ch_ready !== exp_ready) begin
            n_fail++; $display("FAIL rr_ready_%0d: got %b want %b", k, ch_ready, exp_ready);
         end
         tick();  // SEND
         n_checks++;
         if (xfer_ch !== 2'(exp_order[k]) || xfer_data !== 4'(exp_order[k] + 1)) begin
            n_fail++; $display("FAIL rr_xfer_%0d: got ch=%0d data=%h want %0d/%0d",
                               k, xfer_ch, xfer_data, exp_order[k], exp_order[k] + 1);
         end
         tick();  // WAIT_ACK
         xfer_ack = 1'b1;
         tick();  // IDLE
         xfer_ack = 1'b0;
      end
      ch_valid = '0;
   endtask

   task automatic test_wrap();
      do_reset();
      ch_valid = 4'b0100;  // move rr_ptr to 3
      ch_data  = 16'h7654;
      tick();
      ch_valid = '0;
      tick();
      xfer_ack = 1'b1;
      tick();
      xfer_ack = 1'b0;
      ch_valid = 4'b0011;
      #1;
      n_checks++;
      if (ch_ready !== 4'b0001) begin
         n_fail++; $display("FAIL wrap_ready: got %b want 0001", ch_ready);
      end
      tick();
      n_checks++;
      if (xfer_ch !== 2'd0 || xfer_data !== 4'h4) begin
         n_fail++; $display("FAIL wrap_xfer: got ch=%0d data=%h want 0/4", xfer_ch, xfer_data);
      end
      tick();
      xfer_ack = 1'b1;
      tick();
      xfer_ack = 1'b0;
      #1;
      n_checks++;
      if (ch_ready !== 4'b0010) begin
         n_fail++; $display("FAIL wrap_next_ready: got %b want 0010", ch_ready);
      end
      ch_valid = '0;
      tick();
   endtask

   task automatic test_spurious_and_reset();
      do_reset();
      xfer_ack = 1'b1;  // IDLE, no requests
      tick();
      tick();
      n_checks++;
      if (busy !== 1'b0 || ch_ready !== 4'b0000) begin
         n_fail++; $display("FAIL idle_ack: got busy=%b ready=%b want 0/0000", busy, ch_ready);
      end
      xfer_ack = 1'b0;
      ch_valid = 4'b1000;
      ch_data  = 16'hC000;
      tick();  // SEND
      ch_valid = '0;
      xfer_ack = 1'b1;
      tick();  // WAIT_ACK; ack during SEND ignored
      xfer_ack = 1'b0;
      tick();
      tick();
      n_checks++;
      if (busy !== 1'b1 || xfer_data !== 4'hC || xfer_ch !== 2'd3) begin
         n_fail++; $display("FAIL send_ack_ignored: got busy=%b data=%h ch=%0d want 1/c/3",
                            busy, xfer_data, xfer_ch);
      end
      rst      = 1'b1;
      ch_valid = 4'b1111;
      tick();
      n_checks++;
      if ({busy, xfer_req, timeout_err, ch_ready, xfer_data, xfer_ch} !== 13'h0) begin
         n_fail++; $display("FAIL rst_mid_wait: got busy=%b req=%b err=%b ready=%b data=%h ch=%0d want all 0",
                            busy, xfer_req, timeout_err, ch_ready, xfer_data, xfer_ch);
      end
      // Reset landing on the SEND cycle must not emit xfer_req.
      rst      = 1'b0;
      ch_valid = 4'b0001;
      tick();  // SEND
      ch_valid = '0;
      rst      = 1'b1;
      #1;
      n_checks++;
      if (xfer_req !== 1'b0) begin
         n_fail++; $display("FAIL rst_in_send_req: got %b want 0", xfer_req);
      end
      tick();
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_in_send_busy: got %b want 0", busy);
      end
   endtask

`ifdef HS_MULTI_SOURCE_TIMEOUT_EN
   task automatic test_timeout();
      int early_err;
      do_reset();
      ch_valid = 4'b0001;
      ch_data  = 16'h0009;
      tick();  // T+1 SEND
      ch_valid = '0;
      early_err = 0;
      for (int c = 0; c < 8; c++) begin
         tick();  // T+2 .. T+9 WAIT_ACK
         if (timeout_err !== 1'b0 || busy !== 1'b1) early_err++;
      end
      n_checks++;
      if (early_err !== 0) begin
         n_fail++; $display("FAIL to_early: got %0d bad cycles want 0", early_err);
      end
      tick();  // T+10
      n_checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL to_pulse: got err=%b busy=%b want 1/0", timeout_err, busy);
      end
      ch_valid = 4'b0011;  // rr_ptr already advanced to 1
      tick();
      n_checks++;
      if (timeout_err !== 1'b0 || xfer_ch !== 2'd1) begin
         n_fail++; $display("FAIL to_after: got err=%b ch=%0d want 0/1", timeout_err, xfer_ch);
      end
      ch_valid = '0;
      // Same transfer again, ack arrives on the last WAIT_ACK cycle.
      for (int c = 0; c < 7; c++) tick();  // WAIT_ACK up to T+8
      tick();  // T+9
      xfer_ack = 1'b1;
      tick();
      xfer_ack = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL to_ack_wins: got err=%b busy=%b want 0/0", timeout_err, busy);
      end
   endtask
`else
   task automatic test_timeout();
      int bad;
      do_reset();
      ch_valid = 4'b0001;
      tick();
      ch_valid = '0;
      bad = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (timeout_err !== 1'b0 || busy !== 1'b1) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL no_timeout_wait: got %0d bad cycles want 0", bad);
      end
      xfer_ack = 1'b1;
      tick();
      xfer_ack = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL no_timeout_ack: got busy=%b want 0", busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_spurious_and_reset();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
